// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory fetch handshake between pc_fetch_unit (master) and the memory (slave).
interface pc_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;

  modport master (output imem_req, output imem_addr, input imem_rdata, input imem_ack);
  modport slave  (input imem_req, input imem_addr, output imem_rdata, output imem_ack);
endinterface

// File: rtl/pc_fetch_unit.sv
// Multi-cycle fetch/execute PC sequencer: BOOT -> FETCH (wait for ack) -> EXEC (one strobe) -> FETCH.
// Optional macro PC_STATUS_FLAGS_EN: bgez/balz test registered flags from the previous instruction.
module pc_fetch_unit (
  input  logic               clk,
  input  logic               rst_n,
  pc_fetch_unit_if.master    imem,
  output logic [31:0]        instr,
  output logic               instr_valid,
  output logic [31:0]        pc,
  output logic [31:0]        link_addr,
  input  logic [2:0]         bnj,
  input  logic               zero,
  input  logic               neg,
  input  logic [31:0]        jm_target,
  input  logic               hold
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    BNJ_SEQ  = 3'b000,
    BNJ_J    = 3'b001,
    BNJ_BEQ  = 3'b010,
    BNJ_BGEZ = 3'b011,
    BNJ_BALZ = 3'b100,
    BNJ_JM   = 3'b101
  } bnj_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_br_target;
  logic [31:0] w_next_pc;
  logic        w_cond_z;
  logic        w_cond_n;
  logic        w_exec_done;

  assign w_exec_done = (r_state == S_EXEC) && !hold;

  // NOTE: every variable written in this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_BOOT:  w_state_nxt = S_FETCH;
      S_FETCH: if (imem.imem_ack) w_state_nxt = S_EXEC;
      S_EXEC:  if (!hold) w_state_nxt = S_FETCH;
      default: w_state_nxt = S_BOOT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_BOOT;
      r_pc    <= 32'h0000_0000;
      r_instr <= 32'h0000_0000;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == S_FETCH) && imem.imem_ack) r_instr <= imem.imem_rdata;
      if (w_exec_done) r_pc <= w_next_pc;
    end
  end

`ifdef PC_STATUS_FLAGS_EN
  logic r_flag_z;
  logic r_flag_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flag_z <= 1'b0;
      r_flag_n <= 1'b0;
    end else if (w_exec_done) begin
      r_flag_z <= zero;
      r_flag_n <= neg;
    end
  end

  // Flags hold the previous instruction's ALU result during the current EXEC.
  assign w_cond_z = r_flag_z;
  assign w_cond_n = r_flag_n;
`else
  assign w_cond_z = zero;
  assign w_cond_n = neg;
`endif

  assign w_pc_plus4  = r_pc + 32'd4;
  assign w_br_target = w_pc_plus4 + {{14{r_instr[15]}}, r_instr[15:0], 2'b00};

  always_comb begin
    w_next_pc = w_pc_plus4;
    case (bnj_t'(bnj))
      BNJ_J:    w_next_pc = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
      BNJ_BEQ:  if (zero) w_next_pc = w_br_target;
      BNJ_BGEZ: if (!w_cond_n) w_next_pc = w_br_target;
      BNJ_BALZ: if (w_cond_z) w_next_pc = w_br_target;
      BNJ_JM:   w_next_pc = jm_target & 32'hFFFF_FFFC;
      default:  w_next_pc = w_pc_plus4;
    endcase
  end

  assign imem.imem_req  = (r_state == S_FETCH);
  assign imem.imem_addr = r_pc;
  assign instr          = r_instr;
  assign instr_valid    = (r_state == S_EXEC);
  assign pc             = r_pc;
  assign link_addr      = w_pc_plus4;

endmodule
